// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared MIPS decode constants and FSM state encodings for the hazard/stall controller.
package hazard_stall_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [3:0] F4_JR    = 4'b1000;
    localparam logic [3:0] F4_JALR  = 4'b1001;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_e;

    // $0 is hardwired, so writing it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
        return (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational hazard detection: how many bubbles the instruction in ID needs (0..2).
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] IfIdRs,
    input  logic [4:0] IfIdRt,
    input  logic [5:0] IfId_Opcode,
    input  logic [3:0] IfId_Funct4b,
    input  logic [4:0] IdExRd,
    input  logic       IdEx_RegWrite,
    input  logic       IdEx_MemRead,
    input  logic [4:0] ExMemRd,
    input  logic       ExMem_MemRead,
    output logic [1:0] need_o
);

    logic br_use;
    logic ex_hit;
    logic mem_hit;

    always_comb begin
        br_use  = (IfId_Opcode == OP_BEQ) || (IfId_Opcode == OP_BNE) ||
                  ((IfId_Opcode == OP_RTYPE) &&
                   ((IfId_Funct4b == F4_JR) || (IfId_Funct4b == F4_JALR)));
        ex_hit  = reg_hit(IdExRd, IfIdRs, IfIdRt);
        mem_hit = reg_hit(ExMemRd, IfIdRs, IfIdRt);

        need_o = 2'd0;
        if (IdEx_MemRead && ex_hit)
            need_o = 2'd1;
        if (br_use && IdEx_RegWrite && !IdEx_MemRead && ex_hit)
            need_o = 2'd1;
        if (br_use && ExMem_MemRead && mem_hit)
            need_o = 2'd1;
        // A branch on a value still being loaded in EX waits for it to clear MEM.
        if (br_use && IdEx_MemRead && ex_hit)
            need_o = 2'd2;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: post-reset init hold, counted hazard bubbles, branch flush, cache freeze.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W     = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IfIdRs,
    input  logic [4:0]       IfIdRt,
    input  logic [5:0]       IfId_Opcode,
    input  logic [3:0]       IfId_Funct4b,
    input  logic [4:0]       IdExRd,
    input  logic             IdEx_RegWrite,
    input  logic             IdEx_MemRead,
    input  logic [4:0]       ExMemRd,
    input  logic             ExMem_MemRead,
    input  logic             Br_taken,
    input  logic             ICache_stall,
    input  logic             DCache_stall,
    output logic             PC_write,
    output logic             IfId_write,
    output logic             IfId_flush,
    output logic             IdEx_flush,
    output logic             Pipe_write,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] Perf_stall_cyc,
    output logic [CNT_W-1:0] Perf_bubble,
    output logic [CNT_W-1:0] Perf_flush,
`endif
    output logic             Stall_busy
);

    localparam int CW = (INIT_CYCLES > 4) ? $clog2(INIT_CYCLES) : 2;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    need;
    logic          frz;
    logic          bubble;

    hazard_detect u_detect (
        .IfIdRs        (IfIdRs),
        .IfIdRt        (IfIdRt),
        .IfId_Opcode   (IfId_Opcode),
        .IfId_Funct4b  (IfId_Funct4b),
        .IdExRd        (IdExRd),
        .IdEx_RegWrite (IdEx_RegWrite),
        .IdEx_MemRead  (IdEx_MemRead),
        .ExMemRd       (ExMemRd),
        .ExMem_MemRead (ExMem_MemRead),
        .need_o        (need)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= CW'(INIT_CYCLES - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first bubble is issued from S_RUN, so S_STALL only covers the
    // remaining ones; cnt counts S_STALL cycles still owed after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!frz) begin
            case (state_q)
                S_INIT: begin
                    if (cnt_q == '0) state_d = S_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_RUN: begin
                    if (need > 2'd1) begin
                        state_d = S_STALL;
                        cnt_d   = CW'(need - 2'd2);
                    end
                end
                S_STALL: begin
                    if (cnt_q == '0) state_d = S_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        frz        = ICache_stall | DCache_stall;
        bubble     = ((state_q == S_RUN) && (need != 2'd0)) || (state_q == S_STALL);
        PC_write   = 1'b1;
        IfId_write = 1'b1;
        IfId_flush = 1'b0;
        IdEx_flush = 1'b0;
        Pipe_write = 1'b1;
        if (state_q == S_INIT) begin
            PC_write   = 1'b0;
            IfId_write = 1'b0;
            IfId_flush = 1'b1;
            IdEx_flush = 1'b1;
            Pipe_write = !frz;
        end else if (frz) begin
            PC_write   = 1'b0;
            IfId_write = 1'b0;
            Pipe_write = 1'b0;
        end else if (bubble) begin
            PC_write   = 1'b0;
            IfId_write = 1'b0;
            IdEx_flush = 1'b1;
        end else begin
            IfId_flush = Br_taken;
        end
        Stall_busy = (state_q != S_RUN);
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cyc_q, bubble_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            bubble_q    <= '0;
            flush_q     <= '0;
        end else begin
            if (frz && (stall_cyc_q != '1))
                stall_cyc_q <= stall_cyc_q + 1'b1;
            if (IdEx_flush && (state_q != S_INIT) && (bubble_q != '1))
                bubble_q <= bubble_q + 1'b1;
            if (IfId_flush && (state_q != S_INIT) && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign Perf_stall_cyc = stall_cyc_q;
    assign Perf_bubble    = bubble_q;
    assign Perf_flush     = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: the driver queues expected control vectors, a negedge monitor checks them.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IfIdRs, IfIdRt, IdExRd, ExMemRd;
    logic [5:0] IfId_Opcode;
    logic [3:0] IfId_Funct4b;
    logic       IdEx_RegWrite, IdEx_MemRead, ExMem_MemRead;
    logic       Br_taken, ICache_stall, DCache_stall;
    logic       PC_write, IfId_write, IfId_flush, IdEx_flush, Pipe_write, Stall_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] Perf_stall_cyc, Perf_bubble, Perf_flush;
    logic [31:0] perf_b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // {PC_write, IfId_write, IfId_flush, IdEx_flush, Pipe_write, Stall_busy}
    localparam logic [5:0] E_INIT   = 6'b001111;
    localparam logic [5:0] E_RUN    = 6'b110010;
    localparam logic [5:0] E_BR     = 6'b111010;
    localparam logic [5:0] E_BUB1   = 6'b000110;
    localparam logic [5:0] E_BUB2   = 6'b000111;
    localparam logic [5:0] E_FRZRUN = 6'b000000;
    localparam logic [5:0] E_FRZSTL = 6'b000001;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_JR   = 4'b1000;

    logic [5:0] exp_q[$];
    int         id_q[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.INIT_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .IfIdRs        (IfIdRs),
        .IfIdRt        (IfIdRt),
        .IfId_Opcode   (IfId_Opcode),
        .IfId_Funct4b  (IfId_Funct4b),
        .IdExRd        (IdExRd),
        .IdEx_RegWrite (IdEx_RegWrite),
        .IdEx_MemRead  (IdEx_MemRead),
        .ExMemRd       (ExMemRd),
        .ExMem_MemRead (ExMem_MemRead),
        .Br_taken      (Br_taken),
        .ICache_stall  (ICache_stall),
        .DCache_stall  (DCache_stall),
        .PC_write      (PC_write),
        .IfId_write    (IfId_write),
        .IfId_flush    (IfId_flush),
        .IdEx_flush    (IdEx_flush),
        .Pipe_write    (Pipe_write),
`ifdef HAZ_PERF_CNT_EN
        .Perf_stall_cyc(Perf_stall_cyc),
        .Perf_bubble   (Perf_bubble),
        .Perf_flush    (Perf_flush),
`endif
        .Stall_busy    (Stall_busy)
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e, a;
            int         id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = {PC_write, IfId_write, IfId_flush, IdEx_flush, Pipe_write, Stall_busy};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL step%0d ctrl: got %b expected %b", id, a, e);
            end
        end
    end

    int step_no = 0;

    task automatic idle_pipe();
        IfIdRs = 5'd0; IfIdRt = 5'd0; IfId_Opcode = OP_R; IfId_Funct4b = F_ADD;
        IdExRd = 5'd0; IdEx_RegWrite = 1'b0; IdEx_MemRead = 1'b0;
        ExMemRd = 5'd0; ExMem_MemRead = 1'b0;
        Br_taken = 1'b0; ICache_stall = 1'b0; DCache_stall = 1'b0;
    endtask

    // One clock cycle: new inputs just after the edge, expectation queued for this cycle.
    task automatic step(input logic r,
                        input logic [5:0] op, input logic [3:0] f4,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] exrd, input logic exwr, input logic exld,
                        input logic [4:0] memrd, input logic memld,
                        input logic br, input logic dstall,
                        input logic [5:0] e);
        @(posedge clk);
        #1;
        rst = r;
        IfId_Opcode = op; IfId_Funct4b = f4; IfIdRs = rs; IfIdRt = rt;
        IdExRd = exrd; IdEx_RegWrite = exwr; IdEx_MemRead = exld;
        ExMemRd = memrd; ExMem_MemRead = memld;
        Br_taken = br; DCache_stall = dstall;
        step_no++;
        exp_q.push_back(e);
        id_q.push_back(step_no);
    endtask

    task automatic run_idle(input logic [5:0] e);
        step(1'b0, OP_R, F_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e);
    endtask

    initial begin
        rst = 1'b1;
        idle_pipe();
        // reset and init hold
        step(1'b1, OP_R, F_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_INIT);
        run_idle(E_INIT);
        run_idle(E_INIT);
        run_idle(E_RUN);
        // taken branch with no hazard flushes IF/ID
        step(1'b0, OP_BEQ, F_ADD, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0, E_BR);

        // lw $8 in EX, add $9,$8,$1 in ID -> single bubble
        step(1'b0, OP_R, F_ADD, 5'd8, 5'd1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_BUB1);
        step(1'b0, OP_R, F_ADD, 5'd8, 5'd1, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, E_RUN);
        // load-use on rt side
        step(1'b0, OP_R, F_ADD, 5'd2, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_BUB1);
        run_idle(E_RUN);

`ifdef HAZ_PERF_CNT_EN
        perf_b0 = Perf_bubble;
`endif
        // lw $8 in EX, beq $8,$0 in ID -> 2 bubbles, no re-detect, Br_taken ignored
        step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_BUB1);
        step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, E_BUB2);
        step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN);
`ifdef HAZ_PERF_CNT_EN
        @(negedge clk);
        n_cmp++;
        if (Perf_bubble - perf_b0 !== 32'd2) begin
            n_bad++;
            $display("FAIL perf_bubble delta: got %0d expected 2", Perf_bubble - perf_b0);
        end
`endif

        // add $8 in EX, jr $8 in ID -> 1 bubble, then taken jump flushes
        step(1'b0, OP_R, F_JR, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_BUB1);
        step(1'b0, OP_R, F_JR, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0, E_BR);
        // branch on load result sitting in MEM -> 1 bubble
        step(1'b0, OP_BEQ, F_ADD, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, E_BUB1);
        run_idle(E_RUN);

        // DCache freeze for 3 cycles after bubble 1 of the load/branch case
        step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_BUB1);
        for (int i = 0; i < 3; i++)
            step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, E_FRZSTL);
        step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, E_BUB2);
        step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN);
        // freeze in run suppresses branch flush
        step(1'b0, OP_BEQ, F_ADD, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_FRZRUN);

        // $0 destinations never stall
        step(1'b0, OP_R, F_ADD, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN);
        step(1'b0, OP_BEQ, F_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, E_RUN);
        step(1'b0, OP_R, F_JR, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_BR);

        // reset mid-bubble restarts init
        step(1'b0, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_BUB1);
        step(1'b1, OP_BEQ, F_ADD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, E_INIT);
        run_idle(E_INIT);
        run_idle(E_INIT);
        run_idle(E_RUN);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d checks left unconsumed, expected 0", exp_q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
